// File: rtl/priority_scan_encoder.sv
// Priority scan encoder: accepts a request mask and emits the index of
// every set bit, one per cycle, in LSB-first or MSB-first order.
// Ports:
//   clk, clr (async active-low reset)
//   i[WIDTH], i_valid, i_ready : mask input handshake
//   o[IDXW], o_valid, o_ready  : index output handshake
//   o_last : final index of the mask, o_none : mask was all-zero
//   o_count[IDXW+1] : popcount of accepted mask (PRIORITY_SCAN_COUNT_EN)
module priority_scan_encoder #(
  parameter int WIDTH     = 32,
  parameter int IDXW      = 5,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] i,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [IDXW-1:0]  o,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             o_last,
  output logic             o_none
`ifdef PRIORITY_SCAN_COUNT_EN
  ,
  output logic [IDXW:0]    o_count
`endif
);

  if (IDXW != $clog2(WIDTH)) begin : g_bad_idxw
    $error("IDXW must equal clog2(WIDTH)");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] hit_sel;
  logic [IDXW-1:0]  hit_idx;
  logic             multi;
  logic             empty;
  logic             accept;
  logic             fire;

  // Walk the mask so that the winning bit is the last one assigned:
  // ascending for MSB-first, descending for LSB-first.
  always_comb begin
    hit_idx = '0;
    hit_sel = '0;
    for (int k = 0; k < WIDTH; k++) begin
      int j;
      j = MSB_FIRST ? k : (WIDTH - 1 - k);
      if (pending[j]) begin
        hit_idx    = IDXW'(j);
        hit_sel    = '0;
        hit_sel[j] = 1'b1;
      end
    end
  end

  // More than one bit left <=> clearing the lowest bit leaves something.
  assign multi = |(pending & (pending - WIDTH'(1)));
  assign empty = ~|pending;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    i_ready  = 1'b0;
    o_valid  = 1'b0;
    o        = '0;
    o_last   = 1'b0;
    o_none   = 1'b0;
    accept   = 1'b0;
    fire     = 1'b0;
    unique case (state)
      IDLE: begin
        i_ready = 1'b1;
        accept  = i_valid;
        if (i_valid) begin
          state_nx = SCAN;
        end
      end
      SCAN: begin
        o_valid = 1'b1;
        // Pending is only zero in SCAN for an all-zero mask.
        o_none  = empty;
        o       = empty ? '1 : hit_idx;
        o_last  = empty | ~multi;
        fire    = o_ready;
        if (o_ready && o_last) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pending <= '0;
    end else if (accept) begin
      pending <= i;
    end else if (fire) begin
      pending <= pending & ~hit_sel;
    end
  end

`ifdef PRIORITY_SCAN_COUNT_EN
  logic [IDXW:0] pop;

  always_comb begin
    pop = '0;
    for (int k = 0; k < WIDTH; k++) begin
      pop = pop + (IDXW+1)'(i[k]);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      o_count <= '0;
    end else if (accept) begin
      o_count <= pop;
    end
  end
`endif

endmodule
